// File: rtl/answer_gen_pkg.sv
// Shared types and constants for the answer generator: FSM states, the BCD
// digit ceiling and the Galois feedback mask for x^16+x^14+x^13+x^11+1.
package answer_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0]  BCD_MAX   = 4'd9;
    // Right-shifting Galois form: exponents 16,14,13,11 land on bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/lfsr_galois.sv
// Free-running right-shift Galois LFSR. A zero seed would lock up, so it is
// replaced by 1. Only the low OUT_W bits are exported as random data.
module lfsr_galois #(
    parameter int           W     = 16,
    parameter logic [W-1:0] SEED  = W'(1),
    parameter logic [W-1:0] TAPS  = '0,
    parameter int           OUT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic [OUT_W-1:0] rnd
);

    localparam logic [W-1:0] INIT = (SEED == '0) ? W'(1) : SEED;

    logic [W-1:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= INIT;
        else     lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
    end

    assign rnd = lfsr[OUT_W-1:0];

endmodule

// File: rtl/answer_gen.sv
// Draws the secret BCD answer digits for the guessing game and steps the
// difficulty whenever the comparator's round counter wraps to zero.
module answer_gen
    import answer_gen_pkg::*;
#(
    parameter int                LFSR_W     = 16,
    parameter logic [LFSR_W-1:0] SEED       = 16'hACE1,
    parameter int                MAX_TRIES  = 4,
    parameter int                LAST_LEVEL = 3
) (
    input  logic       clk,
    input  logic       restart,
    input  logic       start,
    input  logic [2:0] round_in,
    output logic [3:0] answer0,
    output logic [3:0] answer1,
    output logic [3:0] answer2,
    output logic [1:0] Max_digit,
    output logic       answer_valid,
    output logic       game_done,
    output logic [1:0] state_dbg
);

    localparam int TW = $clog2(MAX_TRIES + 1);

    state_t        state, state_next;
    logic [3:0]    nib;
    logic [3:0]    digits [3];
    logic [2:0]    prev_round;
    logic [1:0]    digit_idx;
    logic [TW-1:0] try_cnt;
    logic [1:0]    max_next;
    logic          draw_enter;
    logic          is_ms;
    logic          nib_ok;
    logic          take;
    logic [3:0]    digit_val;

    lfsr_galois #(
        .W     (LFSR_W),
        .SEED  (SEED),
        .TAPS  (LFSR_TAPS),
        .OUT_W (4)
    ) u_lfsr (
        .clk (clk),
        .rst (restart),
        .rnd (nib)
    );

    always_comb begin
        is_ms      = (digit_idx == Max_digit - 2'd1);
        nib_ok     = (nib <= BCD_MAX) && !(is_ms && (Max_digit > 2'd1) && (nib == 4'd0));
        take       = nib_ok || (try_cnt == TW'(MAX_TRIES));
        // Once the retry budget is spent the nibble is folded into range instead.
        digit_val  = nib_ok ? nib : ((nib > BCD_MAX) ? nib - 4'd6 : 4'd1);
        state_next = state;
        draw_enter = 1'b0;
        max_next   = Max_digit;
        case (state)
            IDLE: if (start) begin
                state_next = DRAW;
                draw_enter = 1'b1;
                max_next   = 2'd1;
            end
            DRAW: if (take && is_ms) state_next = HOLD;
            HOLD: if (round_in != prev_round) begin
                if (round_in != 3'd0) begin
                    state_next = DRAW;
                    draw_enter = 1'b1;
                end else if (Max_digit < 2'(LAST_LEVEL)) begin
                    state_next = DRAW;
                    draw_enter = 1'b1;
                    max_next   = Max_digit + 2'd1;
                end else begin
                    state_next = DONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge restart) begin
        if (restart) state <= IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge clk or posedge restart) begin
        if (restart) begin
            digits       <= '{default: 4'd0};
            Max_digit    <= 2'd0;
            answer_valid <= 1'b0;
            prev_round   <= 3'd1;
            digit_idx    <= 2'd0;
            try_cnt      <= '0;
        end else begin
            Max_digit <= max_next;
            if (draw_enter) begin
                answer_valid <= 1'b0;
                digit_idx    <= 2'd0;
                try_cnt      <= '0;
                for (int i = 0; i < 3; i++) begin
                    if (i >= int'(max_next)) digits[i] <= 4'd0;
                end
            end else if (state == DRAW) begin
                if (take) begin
                    digits[digit_idx] <= digit_val;
                    digit_idx         <= digit_idx + 2'd1;
                    try_cnt           <= '0;
                    // Round is sampled as the answer becomes visible; later moves show up in HOLD.
                    if (is_ms) begin
                        answer_valid <= 1'b1;
                        prev_round   <= round_in;
                    end
                end else begin
                    try_cnt <= try_cnt + TW'(1);
                end
            end
        end
    end

    assign answer0   = digits[0];
    assign answer1   = digits[1];
    assign answer2   = digits[2];
    assign game_done = (state == DONE);
    assign state_dbg = state;

endmodule
